// File: rtl/parallel2serial_param.sv
// parallel2serial_param: WIDTH-bit word to framed bit-serial stream.
// Define P2S_PARITY_EN to append an even-parity bit to each frame.
module parallel2serial_param #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             serial_valid,
   output logic             serial_out,
   output logic             serial_start,
   output logic             serial_end,
   output logic             busy
);

`ifdef P2S_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             valid_n, out_n, start_n, end_n;
   logic             accept;
`ifdef P2S_PARITY_EN
   logic             par, par_n;
`endif

   function automatic logic head_of(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? (v << 1) : (v >> 1);
   endfunction

   assign in_ready = !serial_valid || serial_end;
   assign accept   = in_valid && in_ready;
   assign busy     = serial_valid;

   // next-state: load on accept, else shift out or fall back to idle
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      valid_n = 1'b0;
      out_n   = 1'b0;
      start_n = 1'b0;
      end_n   = 1'b0;
`ifdef P2S_PARITY_EN
      par_n   = par;
`endif
      if (accept) begin
         state_n = SHIFT;
         sreg_n  = shift_of(parallel_in);
         cnt_n   = LAST;
         valid_n = 1'b1;
         out_n   = head_of(parallel_in);
         start_n = 1'b1;
         end_n   = (LAST == '0);
`ifdef P2S_PARITY_EN
         par_n   = ^parallel_in;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               state_n = IDLE;
            end
            SHIFT: begin
               if (cnt != '0) begin
                  valid_n = 1'b1;
                  end_n   = (cnt == CW'(1));
                  cnt_n   = cnt - CW'(1);
`ifdef P2S_PARITY_EN
                  if (cnt == CW'(1)) begin
                     out_n = par;
                  end else begin
                     out_n  = head_of(sreg);
                     sreg_n = shift_of(sreg);
                  end
`else
                  out_n  = head_of(sreg);
                  sreg_n = shift_of(sreg);
`endif
               end else begin
                  state_n = IDLE;
                  sreg_n  = '0;
                  cnt_n   = '0;
               end
            end
         endcase
      end
   end

   // state and registered serial outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sreg         <= '0;
         cnt          <= '0;
         serial_valid <= 1'b0;
         serial_out   <= 1'b0;
         serial_start <= 1'b0;
         serial_end   <= 1'b0;
`ifdef P2S_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         sreg         <= sreg_n;
         cnt          <= cnt_n;
         serial_valid <= valid_n;
         serial_out   <= out_n;
         serial_start <= start_n;
         serial_end   <= end_n;
`ifdef P2S_PARITY_EN
         par          <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_parallel2serial_param.sv
// tb_parallel2serial_param: directed frames through three configs.
// Parity expectations follow P2S_PARITY_EN.
module tb_parallel2serial_param;

`ifdef P2S_PARITY_EN
   localparam int FR  = 9;
   localparam int FR1 = 2;
`else
   localparam int FR  = 8;
   localparam int FR1 = 1;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] pd;
   int         sel;

   logic iv0, iv1, iv2;
   logic r0, v0, o0, s0, e0, b0;
   logic r1, v1, o1, s1, e1, b1;
   logic r2, v2, o2, s2, e2, b2;
   logic m_r, m_v, m_o, m_s, m_e, m_b;

   logic [31:0] cv, co, cs, ce, cr, cb;
   int tests;
   int fails;

   assign iv0 = in_valid && (sel == 0);
   assign iv1 = in_valid && (sel == 1);
   assign iv2 = in_valid && (sel == 2);

   parallel2serial_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(r0),
      .parallel_in(pd), .serial_valid(v0), .serial_out(o0),
      .serial_start(s0), .serial_end(e0), .busy(b0));

   parallel2serial_param #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(r1),
      .parallel_in(pd), .serial_valid(v1), .serial_out(o1),
      .serial_start(s1), .serial_end(e1), .busy(b1));

   parallel2serial_param #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(r2),
      .parallel_in(pd[0]), .serial_valid(v2), .serial_out(o2),
      .serial_start(s2), .serial_end(e2), .busy(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      {m_r, m_v, m_o, m_s, m_e, m_b} = {r0, v0, o0, s0, e0, b0};
      if (sel == 1) {m_r, m_v, m_o, m_s, m_e, m_b} = {r1, v1, o1, s1, e1, b1};
      if (sel == 2) {m_r, m_v, m_o, m_s, m_e, m_b} = {r2, v2, o2, s2, e2, b2};
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // frame data bits followed by the parity bit (if built) and one idle 0
   function automatic logic [31:0] fo(input logic [7:0] bits, input logic p);
`ifdef P2S_PARITY_EN
      return {22'd0, bits, p, 1'b0};
`else
      return {23'd0, bits, 1'b0} | {31'd0, p & 1'b0};
`endif
   endfunction

   task automatic rec();
      @(posedge clk);
      #1;
      cv = {cv[30:0], m_v};
      co = {co[30:0], m_o};
      cs = {cs[30:0], m_s};
      ce = {ce[30:0], m_e};
      cr = {cr[30:0], m_r};
      cb = {cb[30:0], m_b};
   endtask

   task automatic cap(input int n, input logic [31:0] sched,
                      input logic [7:0] d2);
      cv = '0; co = '0; cs = '0; ce = '0; cr = '0; cb = '0;
      for (int i = 0; i < n; i++) begin
         rec();
         in_valid = sched[n-1-i];
         pd = d2;
      end
   endtask

   task automatic single(input string tag, input int fr,
                         input logic [7:0] w, input logic [31:0] oexp);
      logic [31:0] ve;
      in_valid = 1'b1;
      pd = w;
      cap(fr + 1, 32'd0, 8'h00);
      ve = ((32'd1 << fr) - 32'd1) << 1;
      check({tag, ".out"}, co, oexp);
      check({tag, ".valid"}, cv, ve);
      check({tag, ".busy"}, cb, ve);
      check({tag, ".start"}, cs, 32'd1 << fr);
      check({tag, ".end"}, ce, 32'd2);
      check({tag, ".ready"}, cr, 32'd3);
   endtask

   initial begin
      int n;
      logic [31:0] ee;
      tests = 0;
      fails = 0;
      sel = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      pd = 8'h00;

      repeat (3) rec();
      check("reset", {26'd0, m_v, m_o, m_s, m_e, m_b, m_r}, 32'b000001);
      rst = 1'b0;
      rec();
      check("post_reset", {26'd0, m_v, m_o, m_s, m_e, m_b, m_r}, 32'b000001);

      single("msb_d3", FR, 8'b11010011, fo(8'b11010011, 1'b1));
      single("msb_03", FR, 8'h03, fo(8'h03, 1'b0));

      n = 2 * FR + 1;
      in_valid = 1'b1;
      pd = 8'hA5;
      cap(n, ((32'd1 << FR) - 32'd1) << (n - FR), 8'h3C);
`ifdef P2S_PARITY_EN
      check("b2b.out", co, {13'd0, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0});
`else
      check("b2b.out", co, {15'd0, 8'hA5, 8'h3C, 1'b0});
`endif
      check("b2b.valid", cv, ((32'd1 << (2 * FR)) - 32'd1) << 1);
      check("b2b.start", cs, (32'd1 << (n - 1)) | (32'd1 << (n - 1 - FR)));
      ee = (32'd1 << (n - FR)) | 32'd2;
      check("b2b.end", ce, ee);
      check("b2b.ready", cr, ee | 32'd1);

      in_valid = 1'b1;
      pd = 8'hFF;
      cap(3, 32'd0, 8'hFF);
      check("abort.pre_out", co, 32'b111);
      check("abort.pre_end", ce, 32'd0);
      rst = 1'b1;
      in_valid = 1'b1;
      rec();
      check("abort.rst", {26'd0, m_v, m_o, m_s, m_e, m_b, m_r}, 32'b000001);
      rst = 1'b0;
      in_valid = 1'b0;
      rec();
      check("abort.idle", {26'd0, m_v, m_o, m_s, m_e, m_b, m_r}, 32'b000001);
      single("after_abort", FR, 8'h81, fo(8'h81, 1'b0));

      sel = 1;
      single("lsb_d3", FR, 8'b11010011, fo(8'b11001011, 1'b1));

      sel = 2;
`ifdef P2S_PARITY_EN
      single("w1_par", FR1, 8'h01, 32'b110);
`else
      cv = '0; co = '0; cs = '0; ce = '0; cr = '0; cb = '0;
      in_valid = 1'b1;
      pd = 8'h01;
      for (int i = 0; i < 4; i++) begin
         rec();
         in_valid = (i < 2);
         pd = {7'd0, (i == 1)};
      end
      check("w1.out", co, 32'b1010);
      check("w1.valid", cv, 32'b1110);
      check("w1.start", cs, 32'b1110);
      check("w1.end", ce, 32'b1110);
      check("w1.ready", cr, 32'b1111);
      check("w1.frame", FR1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
